// File: rtl/xadc_sampler_pkg.sv
// Shared types and helpers for the XADC sampler: FSM state enums, the queued
// sample record and the byte encodings of the self-synchronizing host frame.
package xadc_pkg;

  localparam logic [6:0] XADC_VAUX4_ADDR  = 7'h14;
  localparam logic [6:0] XADC_VAUX12_ADDR = 7'h1C;
  localparam int         FRAME_SYNC_BIT   = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH
  } acq_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_HDR,
    T_HI,
    T_LO
  } tx_state_t;

  typedef struct packed {
    logic [4:0]  channel;
    logic [11:0] data;
  } sample_t;

  // Only the header carries the sync bit; the host realigns on it.
  function automatic logic [7:0] frame_header(input logic [4:0] ch);
    logic [7:0] b;
    b = {3'b000, ch};
    b[FRAME_SYNC_BIT] = 1'b1;
    return b;
  endfunction

  function automatic logic [7:0] frame_hi(input logic [11:0] d);
    return {1'b0, d[11:5]};
  endfunction

  function automatic logic [7:0] frame_lo(input logic [11:0] d);
    return {3'b000, d[4:0]};
  endfunction

endpackage

// File: rtl/xadc_sampler_if.sv
// XADC status, DRP port and byte-wide AXI-stream bundle seen by the sampler.
// master = the sampler, slave = the XADC wizard plus the FT232H stream sink.
interface xadc_sampler_if;

  logic        eoc;
  logic [4:0]  channel;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  modport master (
    input  eoc, channel, drp_drdy, drp_do, m_tready,
    output drp_den, drp_dwe, drp_daddr, m_tdata, m_tvalid
  );

  modport slave (
    output eoc, channel, drp_drdy, drp_do, m_tready,
    input  drp_den, drp_dwe, drp_daddr, m_tdata, m_tvalid
  );

endinterface

// File: rtl/xadc_sampler_fifo.sv
// Single-clock first-word-fall-through FIFO of sample_t records.
// A write into a full FIFO is accepted only when a pop happens on the same cycle.
module sample_fifo
  import xadc_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    wr_en,
  input  sample_t wr_data,
  input  logic    rd_en,
  output sample_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  sample_t        r_mem [DEPTH];
  logic [AW:0]    r_wrPtr;
  logic [AW:0]    r_rdPtr;
  logic           w_doRd;
  logic           w_doWr;

  assign empty   = (r_wrPtr == r_rdPtr);
  assign full    = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doRd  = rd_en && !empty;
  assign w_doWr  = wr_en && (!full || w_doRd);
  assign rd_data = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doWr) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doRd) r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doWr) r_mem[r_wrPtr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/xadc_sampler.sv
// Reads VAUX4/VAUX12 conversions over DRP on end-of-conversion and streams each
// sample as a 3-byte frame. Define XADC_SAMPLER_DROP_CNT_EN to add drop_count.
module xadc_sampler
  import xadc_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [4:0] CH_A        = XADC_VAUX4_ADDR[4:0],
  parameter logic [4:0] CH_B        = XADC_VAUX12_ADDR[4:0],
  parameter int         DRP_TIMEOUT = 63
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          enable,
  xadc_sampler_if.master bus,
  output logic          busy
`ifdef XADC_SAMPLER_DROP_CNT_EN
  ,
  output logic [15:0]   drop_count
`endif
);

  localparam int TMR_W = $clog2(DRP_TIMEOUT + 1);

  acq_state_t       r_acqState;
  logic [4:0]       r_chan;
  logic [11:0]      r_data;
  logic [TMR_W-1:0] r_timer;
  logic             r_den;
  logic [6:0]       r_daddr;

  tx_state_t        r_txState;
  sample_t          r_txSample;
  logic [7:0]       r_tdata;
  logic             r_tvalid;

  logic             w_hit;
  logic             w_timeout;
  logic             w_hs;
  logic             w_fifoWr;
  logic             w_fifoRd;
  logic             w_fifoFull;
  logic             w_fifoEmpty;
  sample_t          w_fifoWrData;
  sample_t          w_fifoRdData;
  logic             w_unusedDrpLsb;

  assign w_hit     = enable && bus.eoc && (bus.channel == CH_A || bus.channel == CH_B);
  assign w_timeout = (r_timer == TMR_W'(DRP_TIMEOUT - 1));
  assign w_hs      = r_tvalid && bus.m_tready;

  assign w_fifoWr     = (r_acqState == S_PUSH);
  assign w_fifoWrData = '{channel: r_chan, data: r_data};
  // The entry stays queued until its hi byte is accepted, so a stalled frame
  // still occupies a FIFO slot.
  assign w_fifoRd     = (r_txState == T_HI) && w_hs;

  assign w_unusedDrpLsb = ^bus.drp_do[3:0];

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (w_fifoWr),
    .wr_data (w_fifoWrData),
    .rd_en   (w_fifoRd),
    .rd_data (w_fifoRdData),
    .full    (w_fifoFull),
    .empty   (w_fifoEmpty)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acqState <= S_IDLE;
      r_chan     <= '0;
      r_data     <= '0;
      r_timer    <= '0;
      r_den      <= 1'b0;
      r_daddr    <= '0;
    end else begin
      case (r_acqState)
        S_IDLE: begin
          r_den <= 1'b0;
          if (w_hit) begin
            r_chan     <= bus.channel;
            r_daddr    <= {2'b00, bus.channel};
            r_den      <= 1'b1;
            r_acqState <= S_REQ;
          end
        end
        S_REQ: begin
          r_den      <= 1'b0;
          r_timer    <= '0;
          r_acqState <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.drp_drdy) begin
            r_data     <= bus.drp_do[15:4];
            r_acqState <= S_PUSH;
          end else if (w_timeout) begin
            r_acqState <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_PUSH: begin
          r_acqState <= S_IDLE;
        end
        default: begin
          r_den      <= 1'b0;
          r_acqState <= S_IDLE;
        end
      endcase
    end
  end

  // Back-to-back frames reload the header on the lo-byte handshake.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txState  <= T_IDLE;
      r_txSample <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
    end else begin
      case (r_txState)
        T_IDLE: begin
          if (!w_fifoEmpty) begin
            r_txSample <= w_fifoRdData;
            r_tdata    <= frame_header(w_fifoRdData.channel);
            r_tvalid   <= 1'b1;
            r_txState  <= T_HDR;
          end
        end
        T_HDR: begin
          if (w_hs) begin
            r_tdata   <= frame_hi(r_txSample.data);
            r_txState <= T_HI;
          end
        end
        T_HI: begin
          if (w_hs) begin
            r_tdata   <= frame_lo(r_txSample.data);
            r_txState <= T_LO;
          end
        end
        T_LO: begin
          if (w_hs) begin
            if (!w_fifoEmpty) begin
              r_txSample <= w_fifoRdData;
              r_tdata    <= frame_header(w_fifoRdData.channel);
              r_txState  <= T_HDR;
            end else begin
              r_tvalid  <= 1'b0;
              r_txState <= T_IDLE;
            end
          end
        end
        default: begin
          r_tvalid  <= 1'b0;
          r_txState <= T_IDLE;
        end
      endcase
    end
  end

`ifdef XADC_SAMPLER_DROP_CNT_EN
  logic        w_dropBusy;
  logic        w_dropFull;
  logic        w_dropTimeout;
  logic [15:0] r_dropCount;

  assign w_dropBusy    = w_hit && (r_acqState != S_IDLE);
  assign w_dropFull    = (r_acqState == S_PUSH) && w_fifoFull && !w_fifoRd;
  assign w_dropTimeout = (r_acqState == S_WAIT) && !bus.drp_drdy && w_timeout;

  // Coinciding causes in one cycle count as a single drop event.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCount <= '0;
    end else if ((w_dropBusy || w_dropFull || w_dropTimeout) && (r_dropCount != 16'hFFFF)) begin
      r_dropCount <= r_dropCount + 16'd1;
    end
  end

  assign drop_count = r_dropCount;
`endif

  assign bus.drp_den   = r_den;
  assign bus.drp_dwe   = 1'b0;
  assign bus.drp_daddr = r_daddr;
  assign bus.m_tdata   = r_tdata;
  assign bus.m_tvalid  = r_tvalid;

  assign busy = (r_acqState != S_IDLE) || !w_fifoEmpty || (r_txState != T_IDLE);

endmodule

// File: tb/tb_xadc_sampler.sv
// Directed bench for xadc_sampler: a DRP responder model, a byte scoreboard fed
// when each sample is requested, and an AXIS monitor that checks hold rules.
module tb_xadc_sampler;

  localparam int DEPTH = 4;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic enable  = 1'b0;
  logic busy;
`ifdef XADC_SAMPLER_DROP_CNT_EN
  logic [15:0] dropCount;
`endif

  xadc_sampler_if bus ();

  xadc_sampler #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bus        (bus),
    .busy       (busy)
`ifdef XADC_SAMPLER_DROP_CNT_EN
    ,
    .drop_count (dropCount)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  byteQ [$];
  int          denCount = 0;
  int          expDen   = 0;
  int          rxCount  = 0;
  logic        drpRespond = 1'b1;
  int          drpLatency = 3;
  logic [15:0] drpData    = 16'h0000;
  logic        firstAfterReset = 1'b0;
  logic        prevStall = 1'b0;
  logic [7:0]  prevData  = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Frame layout written out bit by bit from the host protocol.
  task automatic expectFrame(input logic [4:0] ch, input logic [15:0] d);
    byteQ.push_back({1'b1, 2'b00, ch});
    byteQ.push_back({1'b0, d[15:9]});
    byteQ.push_back({3'b000, d[8:4]});
  endtask

  task automatic applyStimulus(input logic [4:0] ch);
    @(posedge sys_clk); #1;
    bus.eoc     = 1'b1;
    bus.channel = ch;
    @(posedge sys_clk); #1;
    bus.eoc     = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int maxCycles);
    int n;
    n = 0;
    while ((busy || byteQ.size() != 0) && n < maxCycles) begin
      @(posedge sys_clk); #1;
      n++;
    end
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_sb_empty"}, byteQ.size(), 0);
  endtask

  task automatic waitValid(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (!bus.m_tvalid && n < maxCycles) begin
      @(posedge sys_clk); #1;
      n++;
    end
    checkOutput(tag, bus.m_tvalid, 1);
  endtask

  // DRP responder: answers each read after drpLatency cycles with drpData.
  always begin
    @(negedge sys_clk);
    if (rst_n && bus.drp_den && drpRespond) begin
      repeat (drpLatency) @(posedge sys_clk);
      #1;
      bus.drp_do   = drpData;
      bus.drp_drdy = 1'b1;
      @(posedge sys_clk); #1;
      bus.drp_drdy = 1'b0;
    end
  end

  // Stream monitor: scoreboard pops on handshake, stall hold rules every cycle.
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      prevStall = 1'b0;
    end else begin
      if (bus.drp_den) denCount++;
      if (prevStall) begin
        checkOutput("tvalid_hold", bus.m_tvalid, 1);
        checkOutput("tdata_hold", bus.m_tdata, prevData);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        rxCount++;
        if (firstAfterReset) begin
          checkOutput("resync_hdr_bit7", bus.m_tdata[7], 1);
          firstAfterReset = 1'b0;
        end
        checkOutput("byte_expected", byteQ.size() != 0, 1);
        if (byteQ.size() != 0) checkOutput("stream_byte", bus.m_tdata, byteQ.pop_front());
      end
      prevStall = bus.m_tvalid && !bus.m_tready;
      prevData  = bus.m_tdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bus.eoc      = 1'b0;
    bus.channel  = 5'h00;
    bus.drp_drdy = 1'b0;
    bus.drp_do   = 16'h0000;
    bus.m_tready = 1'b0;

    // Reset state
    repeat (3) @(posedge sys_clk); #1;
    checkOutput("rst_drp_den", bus.drp_den, 0);
    checkOutput("rst_drp_dwe", bus.drp_dwe, 0);
    checkOutput("rst_drp_daddr", bus.drp_daddr, 0);
    checkOutput("rst_tvalid", bus.m_tvalid, 0);
    checkOutput("rst_tdata", bus.m_tdata, 0);
    checkOutput("rst_busy", busy, 0);
`ifdef XADC_SAMPLER_DROP_CNT_EN
    checkOutput("rst_drop_count", dropCount, 0);
`endif
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge sys_clk); #1;

    // Single sample on VAUX4
    bus.m_tready = 1'b1;
    drpData = 16'hABC0;
    expDen++;
    expectFrame(5'h14, 16'hABC0);
    applyStimulus(5'h14);
    checkOutput("single_den_cycle1", bus.drp_den, 1);
    checkOutput("single_daddr", bus.drp_daddr, 7'h14);
    checkOutput("single_busy", busy, 1);
    @(posedge sys_clk); #1;
    checkOutput("single_den_pulse", bus.drp_den, 0);
    waitIdle("single", 50);
    checkOutput("single_den_count", denCount, expDen);
    checkOutput("single_bytes", rxCount, 3);

    // Back-pressure mid-frame
    bus.m_tready = 1'b0;
    drpData = 16'h5A30;
    expDen++;
    expectFrame(5'h1C, 16'h5A30);
    applyStimulus(5'h1C);
    checkOutput("bp_daddr", bus.drp_daddr, 7'h1C);
    waitValid("bp_valid", 30);
    @(posedge sys_clk); #1;
    bus.m_tready = 1'b1;
    @(posedge sys_clk); #1;
    bus.m_tready = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1;
    checkOutput("bp_hi_held", bus.m_tdata, 8'h2D);
    bus.m_tready = 1'b1;
    waitIdle("bp", 30);
    checkOutput("bp_bytes", rxCount, 6);

    // Ignored channel
    applyStimulus(5'h10);
    repeat (10) @(posedge sys_clk);
    #1;
    checkOutput("ign_den_count", denCount, expDen);
    checkOutput("ign_busy", busy, 0);
    checkOutput("ign_bytes", rxCount, 6);

    // FIFO overflow: four samples fit, two are dropped
    bus.m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drpData = 16'h1230 + 16'(i) * 16'h1110;
      expDen++;
      if (i < DEPTH) expectFrame(5'h1C, drpData);
      applyStimulus(5'h1C);
      repeat (8) @(posedge sys_clk);
      #1;
    end
    checkOutput("ovf_den_count", denCount, expDen);
    checkOutput("ovf_busy", busy, 1);
    checkOutput("ovf_head_hdr", bus.m_tdata, 8'h9C);
    bus.m_tready = 1'b1;
    waitIdle("ovf", 60);
    checkOutput("ovf_bytes", rxCount, 18);
`ifdef XADC_SAMPLER_DROP_CNT_EN
    checkOutput("ovf_drop_count", dropCount, 2);
`endif

    // DRP timeout, then a normal read
    drpRespond = 1'b0;
    expDen++;
    applyStimulus(5'h14);
    n = 1;
    while (busy && n < 200) begin
      @(posedge sys_clk);
      n++;
      @(negedge sys_clk);
    end
    checkOutput("tmo_cycles", n, 65);
    checkOutput("tmo_bytes", rxCount, 18);
`ifdef XADC_SAMPLER_DROP_CNT_EN
    checkOutput("tmo_drop_count", dropCount, 3);
`endif
    @(posedge sys_clk); #1;
    drpRespond = 1'b1;
    drpData = 16'h7FF0;
    expDen++;
    expectFrame(5'h14, 16'h7FF0);
    applyStimulus(5'h14);
    waitIdle("post_tmo", 50);
    checkOutput("post_tmo_bytes", rxCount, 21);

    // Enable dropped while the read is in flight; later eoc ignored
    drpData = 16'h0010;
    expDen++;
    expectFrame(5'h1C, 16'h0010);
    applyStimulus(5'h1C);
    enable = 1'b0;
    waitIdle("en_off", 50);
    checkOutput("en_off_bytes", rxCount, 24);
    applyStimulus(5'h1C);
    repeat (10) @(posedge sys_clk);
    #1;
    checkOutput("en_off_den_count", denCount, expDen);
    enable = 1'b1;

    // Reset during the hi byte
    bus.m_tready = 1'b0;
    drpData = 16'h0F10;
    expDen++;
    expectFrame(5'h14, 16'h0F10);
    applyStimulus(5'h14);
    waitValid("rst_mid_valid", 30);
    @(posedge sys_clk); #1;
    bus.m_tready = 1'b1;
    @(posedge sys_clk); #1;
    bus.m_tready = 1'b0;
    checkOutput("rst_mid_hi", bus.m_tdata, 8'h07);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_tvalid", bus.m_tvalid, 0);
    checkOutput("rst_mid_busy", busy, 0);
`ifdef XADC_SAMPLER_DROP_CNT_EN
    checkOutput("rst_mid_drop_count", dropCount, 0);
`endif
    byteQ.delete();
    repeat (3) @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
    firstAfterReset = 1'b1;
    bus.m_tready = 1'b1;
    drpData = 16'h8000;
    expDen++;
    expectFrame(5'h1C, 16'h8000);
    applyStimulus(5'h1C);
    waitIdle("post_rst", 50);
    checkOutput("post_rst_bytes", rxCount, 28);
    checkOutput("post_rst_resync_seen", firstAfterReset, 0);
    checkOutput("final_den_count", denCount, expDen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
